// File: rtl/msfsm_pkg.sv
// Shared definitions for the synchronous-product FSM block: config select codes,
// top-level control states and a width helper.
package msfsm_pkg;

    localparam logic [1:0] CFG_TRANS = 2'd0;
    localparam logic [1:0] CFG_OUTEN = 2'd1;
    localparam logic [1:0] CFG_PART  = 2'd2;

    typedef enum logic {
        S_CFG = 1'b0,
        S_RUN = 1'b1
    } top_state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/msfsm_sync_product_local.sv
// One local Mealy FSM of the product: transition table, participation mask,
// output-enable table and state register, all cleared by reset.
module msfsm_local
    import msfsm_pkg::*;
#(
    parameter int N_STATE = 8,
    parameter int N_EV    = 8,
    parameter int N_OUT   = 2,
    parameter int SW      = $clog2(N_STATE),
    parameter int EW      = $clog2(N_EV),
    parameter int CW      = max(1 + SW, 2 * N_OUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_trans,
    input  logic             wr_outen,
    input  logic             wr_part,
    input  logic [SW-1:0]    cfg_state,
    input  logic [EW-1:0]    cfg_event,
    input  logic [CW-1:0]    cfg_wdata,
    input  logic [EW-1:0]    ev_id,
    input  logic             step,
    input  logic             force_init,
    output logic             en_e,
    output logic [SW-1:0]    state,
    output logic [N_OUT-1:0] outen_p,
    output logic [N_OUT-1:0] outen_m,
    output logic [N_OUT-1:0] outen0_p,
    output logic [N_OUT-1:0] outen0_m
);

    localparam logic [SW:0] NS_W = (SW + 1)'(N_STATE);

    logic                 valid_reg [N_STATE][N_EV];
    logic [SW-1:0]        next_reg  [N_STATE][N_EV];
    logic [2*N_OUT-1:0]   outen_reg [N_STATE];
    logic [N_EV-1:0]      part_reg;
    logic [SW-1:0]        state_reg;

    logic [SW:0]          raw_next;
    logic [SW-1:0]        wr_next;
    logic [SW-1:0]        nxt_state;

    // Out-of-range next-state values wrap back into the table range.
    always_comb begin
        raw_next = {1'b0, cfg_wdata[SW-1:0]};
        wr_next  = (raw_next >= NS_W) ? SW'(raw_next - NS_W) : raw_next[SW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < N_STATE; s++) begin
                outen_reg[s] <= '0;
                for (int e = 0; e < N_EV; e++) begin
                    valid_reg[s][e] <= 1'b0;
                    next_reg[s][e]  <= '0;
                end
            end
            part_reg  <= '0;
            state_reg <= '0;
        end else begin
            if (wr_trans) begin
                valid_reg[cfg_state][cfg_event] <= cfg_wdata[SW];
                next_reg[cfg_state][cfg_event]  <= wr_next;
            end
            if (wr_outen) begin
                outen_reg[cfg_state] <= cfg_wdata[2*N_OUT-1:0];
            end
            if (wr_part) begin
                part_reg[cfg_event] <= cfg_wdata[0];
            end
            if (force_init) begin
                state_reg <= '0;
            end else if (step && part_reg[ev_id]) begin
                state_reg <= next_reg[state_reg][ev_id];
            end
        end
    end

    // Non-participating FSMs never block an event and keep their state.
    always_comb begin
        en_e      = !part_reg[ev_id] || valid_reg[state_reg][ev_id];
        nxt_state = part_reg[ev_id] ? next_reg[state_reg][ev_id] : state_reg;
        outen_p   = outen_reg[nxt_state][N_OUT-1:0];
        outen_m   = outen_reg[nxt_state][2*N_OUT-1:N_OUT];
        outen0_p  = outen_reg[0][N_OUT-1:0];
        outen0_m  = outen_reg[0][2*N_OUT-1:N_OUT];
    end

    assign state = state_reg;

endmodule

// File: rtl/msfsm_sync_product.sv
// Table-driven synchronous product of N_FSM local Mealy FSMs with dual-rail outputs.
// Optional feature macro MSFSM_REJECT_EN: consume disabled events and flag them on ev_err.
module msfsm_sync_product
    import msfsm_pkg::*;
#(
    parameter int N_FSM   = 3,
    parameter int N_STATE = 8,
    parameter int N_EV    = 8,
    parameter int N_OUT   = 2,
    localparam int SW     = $clog2(N_STATE),
    localparam int EW     = $clog2(N_EV),
    localparam int FW     = (N_FSM > 1) ? $clog2(N_FSM) : 1,
    localparam int CW     = max(1 + SW, 2 * N_OUT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_sel,
    input  logic [FW-1:0]       cfg_fsm,
    input  logic [SW-1:0]       cfg_state,
    input  logic [EW-1:0]       cfg_event,
    input  logic [CW-1:0]       cfg_wdata,
    output logic                cfg_err,
    input  logic                start,
    input  logic                stop,
    output logic                running,
    input  logic                ev_valid,
    input  logic [EW-1:0]       ev_id,
    output logic                ev_ready,
    output logic                ev_err,
    output logic [N_FSM*SW-1:0] state_o,
    output logic [N_OUT-1:0]    out_p,
    output logic [N_OUT-1:0]    out_m,
    output logic                dual_err
);

    top_state_t       top_reg, top_next;
    logic [N_OUT-1:0] out_p_reg, out_p_next, out_m_reg, out_m_next;
    logic             dual_err_reg, cfg_err_reg;
    logic             cfg_ok, enabled, step, start_go;

    logic [N_FSM-1:0] en_vec;
    logic [SW-1:0]    state_arr [N_FSM];
    logic [N_OUT-1:0] nxt_p [N_FSM];
    logic [N_OUT-1:0] nxt_m [N_FSM];
    logic [N_OUT-1:0] ini_p [N_FSM];
    logic [N_OUT-1:0] ini_m [N_FSM];
    logic [N_OUT-1:0] red_p, red_m, red_ini_p, red_ini_m;

    assign cfg_ok = cfg_we && (top_reg == S_CFG) && (cfg_sel != 2'd3);

    for (genvar gi = 0; gi < N_FSM; gi++) begin : g_fsm
        logic sel_fsm;
        assign sel_fsm = cfg_ok && (cfg_fsm == FW'(gi));

        msfsm_local #(
            .N_STATE (N_STATE),
            .N_EV    (N_EV),
            .N_OUT   (N_OUT),
            .SW      (SW),
            .EW      (EW),
            .CW      (CW)
        ) u_local (
            .clk        (clk),
            .reset      (reset),
            .wr_trans   (sel_fsm && (cfg_sel == CFG_TRANS)),
            .wr_outen   (sel_fsm && (cfg_sel == CFG_OUTEN)),
            .wr_part    (sel_fsm && (cfg_sel == CFG_PART)),
            .cfg_state  (cfg_state),
            .cfg_event  (cfg_event),
            .cfg_wdata  (cfg_wdata),
            .ev_id      (ev_id),
            .step       (step),
            .force_init (start_go),
            .en_e       (en_vec[gi]),
            .state      (state_arr[gi]),
            .outen_p    (nxt_p[gi]),
            .outen_m    (nxt_m[gi]),
            .outen0_p   (ini_p[gi]),
            .outen0_m   (ini_m[gi])
        );

        assign state_o[gi*SW +: SW] = state_arr[gi];
    end

    always_comb begin
        red_p     = '1;
        red_m     = '1;
        red_ini_p = '1;
        red_ini_m = '1;
        for (int f = 0; f < N_FSM; f++) begin
            red_p     = red_p & nxt_p[f];
            red_m     = red_m & nxt_m[f];
            red_ini_p = red_ini_p & ini_p[f];
            red_ini_m = red_ini_m & ini_m[f];
        end
    end

    // stop outranks both start and a pending event.
    always_comb begin
        enabled    = &en_vec;
        step       = 1'b0;
        start_go   = 1'b0;
        ev_ready   = 1'b0;
        ev_err     = 1'b0;
        top_next   = top_reg;
        out_p_next = out_p_reg;
        out_m_next = out_m_reg;
        case (top_reg)
            S_CFG: begin
                out_p_next = '0;
                out_m_next = '0;
                if (start && !stop) begin
                    start_go   = 1'b1;
                    top_next   = S_RUN;
                    out_p_next = red_ini_p;
                    out_m_next = red_ini_m;
                end
            end
            S_RUN: begin
                if (stop) begin
                    top_next   = S_CFG;
                    out_p_next = '0;
                    out_m_next = '0;
                end else begin
`ifdef MSFSM_REJECT_EN
                    ev_ready = ev_valid;
                    ev_err   = ev_valid && !enabled;
`else
                    ev_ready = ev_valid && enabled;
`endif
                    step = ev_valid && enabled;
                    if (step) begin
                        out_p_next = red_p;
                        out_m_next = red_m;
                    end
                end
            end
            default: top_next = S_CFG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_reg      <= S_CFG;
            out_p_reg    <= '0;
            out_m_reg    <= '0;
            dual_err_reg <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            top_reg      <= top_next;
            out_p_reg    <= out_p_next;
            out_m_reg    <= out_m_next;
            dual_err_reg <= |(out_p_next & out_m_next);
            cfg_err_reg  <= cfg_we && ((top_reg == S_RUN) || (cfg_sel == 2'd3));
        end
    end

    assign running  = (top_reg == S_RUN);
    assign out_p    = out_p_reg;
    assign out_m    = out_m_reg;
    assign dual_err = dual_err_reg;
    assign cfg_err  = cfg_err_reg;

endmodule

// File: tb/tb_msfsm_sync_product.sv
// Directed self-checking bench for msfsm_sync_product at default parameters;
// expectations follow MSFSM_REJECT_EN when the bench is built with it.
module tb_msfsm_sync_product;

    localparam int SW = 3;
    localparam int EW = 3;
    localparam int FW = 2;
    localparam int CW = 4;
`ifdef MSFSM_REJECT_EN
    localparam logic REJ = 1'b1;
`else
    localparam logic REJ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, cfg_we, start, stop, ev_valid;
    logic [1:0]    cfg_sel;
    logic [FW-1:0] cfg_fsm;
    logic [SW-1:0] cfg_state;
    logic [EW-1:0] cfg_event, ev_id;
    logic [CW-1:0] cfg_wdata;
    logic          cfg_err, running, ev_ready, ev_err, dual_err;
    logic [8:0]    state_o;
    logic [1:0]    out_p, out_m;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    msfsm_sync_product dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_fsm(cfg_fsm),
        .cfg_state(cfg_state), .cfg_event(cfg_event), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .start(start), .stop(stop), .running(running), .ev_valid(ev_valid), .ev_id(ev_id),
        .ev_ready(ev_ready), .ev_err(ev_err), .state_o(state_o), .out_p(out_p), .out_m(out_m),
        .dual_err(dual_err)
    );

    task automatic cfg_write(input logic [1:0] sel, input int fsm, input int st, input int ev,
                             input logic [CW-1:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_fsm = FW'(fsm);
        cfg_state = SW'(st); cfg_event = EW'(ev); cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        $display("cfg sel=%0d fsm=%0d st=%0d ev=%0d data=%b cfg_err=%b", sel, fsm, st, ev, d, cfg_err);
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        $display("start running=%b state_o=%o", running, state_o);
    endtask

    task automatic do_stop();
        @(negedge clk); stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        $display("stop running=%b state_o=%o", running, state_o);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        $display("reset running=%b state_o=%o", running, state_o);
    endtask

    task automatic present_event(input int ev, output logic rdy, output logic err);
        @(negedge clk);
        ev_valid = 1'b1; ev_id = EW'(ev);
        #1; rdy = ev_ready; err = ev_err;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        $display("ev %0d ready=%b err=%b state_o=%o out_p=%b out_m=%b dual_err=%b",
                 ev, rdy, err, state_o, out_p, out_m, dual_err);
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_we = 0; start = 0; stop = 0; ev_valid = 0;
        cfg_sel = 0; cfg_fsm = 0; cfg_state = 0; cfg_event = 0; cfg_wdata = 0; ev_id = 0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        @(negedge clk); ev_valid = 1'b1; ev_id = 3'd0; #1;
        n_cmp++; if (ev_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ev_ready: got %b want 0", ev_ready); end
        n_cmp++; if (ev_err !== 1'b0) begin n_bad++; $display("FAIL reset_ev_err: got %b want 0", ev_err); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", running); end
        n_cmp++; if (state_o !== 9'o000) begin n_bad++; $display("FAIL reset_state: got %o want 000", state_o); end
        n_cmp++; if ({out_p, out_m} !== 4'b0000) begin n_bad++; $display("FAIL reset_outs: got %b want 0000", {out_p, out_m}); end
        n_cmp++; if ({dual_err, cfg_err} !== 2'b00) begin n_bad++; $display("FAIL reset_errs: got %b want 00", {dual_err, cfg_err}); end
        @(posedge clk); #1; ev_valid = 1'b0;
    endtask

    task automatic test_enable();
        logic rdy, err;
        cfg_write(2'd2, 0, 0, 3, 4'b0001);
        cfg_write(2'd2, 1, 0, 3, 4'b0001);
        cfg_write(2'd0, 0, 0, 3, 4'b1010);
        cfg_write(2'd2, 0, 0, 4, 4'b0001);
        cfg_write(2'd0, 0, 2, 4, 4'b1110);
        do_start();
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL start_running: got %b want 1", running); end
        present_event(3, rdy, err);
        n_cmp++; if (rdy !== REJ) begin n_bad++; $display("FAIL blocked_ready: got %b want %b", rdy, REJ); end
        n_cmp++; if (err !== REJ) begin n_bad++; $display("FAIL blocked_ev_err: got %b want %b", err, REJ); end
        n_cmp++; if (state_o !== 9'o000) begin n_bad++; $display("FAIL blocked_state: got %o want 000", state_o); end
        present_event(7, rdy, err);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL noop_ready: got %b want 1", rdy); end
        n_cmp++; if (state_o !== 9'o000) begin n_bad++; $display("FAIL noop_state: got %o want 000", state_o); end
        do_stop();
        cfg_write(2'd0, 1, 0, 3, 4'b1101);
        do_start();
        present_event(3, rdy, err);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL sync_ready: got %b want 1", rdy); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL sync_ev_err: got %b want 0", err); end
        n_cmp++; if (state_o !== 9'o052) begin n_bad++; $display("FAIL sync_state: got %o want 052", state_o); end
    endtask

    task automatic test_stop_priority();
        @(negedge clk); stop = 1'b1; ev_valid = 1'b1; ev_id = 3'd4; #1;
        n_cmp++; if (ev_ready !== 1'b0) begin n_bad++; $display("FAIL stop_ev_ready: got %b want 0", ev_ready); end
        @(posedge clk); #1; stop = 1'b0; ev_valid = 1'b0;
        $display("stop+ev running=%b state_o=%o", running, state_o);
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL stop_running: got %b want 0", running); end
        n_cmp++; if (state_o !== 9'o052) begin n_bad++; $display("FAIL stop_state: got %o want 052", state_o); end
    endtask

    task automatic test_cfg_err();
        logic rdy, err;
        cfg_write(2'd3, 0, 0, 0, 4'b1111);
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL sel3_cfg_err: got %b want 1", cfg_err); end
        do_start();
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg_err_clear: got %b want 0", cfg_err); end
        n_cmp++; if (state_o !== 9'o000) begin n_bad++; $display("FAIL restart_state: got %o want 000", state_o); end
        cfg_write(2'd0, 0, 0, 3, 4'b0000);
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL run_cfg_err: got %b want 1", cfg_err); end
        @(posedge clk); #1;
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL run_cfg_err_pulse: got %b want 0", cfg_err); end
        present_event(3, rdy, err);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL table_kept_ready: got %b want 1", rdy); end
        n_cmp++; if (state_o !== 9'o052) begin n_bad++; $display("FAIL table_kept_state: got %o want 052", state_o); end
        present_event(4, rdy, err);
        n_cmp++; if (state_o !== 9'o056) begin n_bad++; $display("FAIL second_step_state: got %o want 056", state_o); end
    endtask

    // Events 0..3 = a_P, a_M, b_P, b_M; FSM2 tracks {b,a} and drives p={a,a^b}, m=~p.
    task automatic test_dual_rail();
        logic rdy, err;
        int          seq_ev  [5] = '{0, 3, 2, 3, 1};
        logic        seq_rdy [5] = '{1'b1, REJ, 1'b1, 1'b1, 1'b1};
        logic        seq_err [5] = '{1'b0, REJ, 1'b0, 1'b0, 1'b0};
        logic [8:0]  seq_st  [5] = '{9'o101, 9'o101, 9'o311, 9'o101, 9'o000};
        logic [1:0]  seq_p   [5] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b00};
        logic [1:0]  seq_m   [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b11};
        do_reset();
        for (int f = 0; f < 2; f++) begin
            cfg_write(2'd2, f, 0, 2*f, 4'b0001);
            cfg_write(2'd2, f, 0, 2*f+1, 4'b0001);
            cfg_write(2'd0, f, 0, 2*f, 4'b1001);
            cfg_write(2'd0, f, 1, 2*f+1, 4'b1000);
            cfg_write(2'd1, f, 0, 0, 4'b1111);
            cfg_write(2'd1, f, 1, 0, 4'b1111);
        end
        for (int e = 0; e < 4; e++) cfg_write(2'd2, 2, 0, e, 4'b0001);
        cfg_write(2'd0, 2, 0, 0, 4'b1001); cfg_write(2'd0, 2, 0, 2, 4'b1010);
        cfg_write(2'd0, 2, 1, 1, 4'b1000); cfg_write(2'd0, 2, 1, 2, 4'b1011);
        cfg_write(2'd0, 2, 2, 0, 4'b1011); cfg_write(2'd0, 2, 2, 3, 4'b1000);
        cfg_write(2'd0, 2, 3, 1, 4'b1010); cfg_write(2'd0, 2, 3, 3, 4'b1001);
        cfg_write(2'd1, 2, 0, 0, 4'b1100); cfg_write(2'd1, 2, 1, 0, 4'b0011);
        cfg_write(2'd1, 2, 2, 0, 4'b1001); cfg_write(2'd1, 2, 3, 0, 4'b0110);
        do_start();
        n_cmp++; if ({out_p, out_m} !== 4'b0011) begin n_bad++; $display("FAIL start_outs: got %b want 0011", {out_p, out_m}); end
        for (int i = 0; i < 5; i++) begin
            present_event(seq_ev[i], rdy, err);
            n_cmp++; if (rdy !== seq_rdy[i]) begin n_bad++; $display("FAIL xor_ready[%0d]: got %b want %b", i, rdy, seq_rdy[i]); end
            n_cmp++; if (err !== seq_err[i]) begin n_bad++; $display("FAIL xor_ev_err[%0d]: got %b want %b", i, err, seq_err[i]); end
            n_cmp++; if (state_o !== seq_st[i]) begin n_bad++; $display("FAIL xor_state[%0d]: got %o want %o", i, state_o, seq_st[i]); end
            n_cmp++; if (out_p !== seq_p[i]) begin n_bad++; $display("FAIL xor_out_p[%0d]: got %b want %b", i, out_p, seq_p[i]); end
            n_cmp++; if (out_m !== seq_m[i]) begin n_bad++; $display("FAIL xor_out_m[%0d]: got %b want %b", i, out_m, seq_m[i]); end
            n_cmp++; if (dual_err !== 1'b0) begin n_bad++; $display("FAIL xor_dual_err[%0d]: got %b want 0", i, dual_err); end
        end
    endtask

    task automatic test_dual_err();
        logic rdy, err;
        present_event(0, rdy, err);
        do_stop();
        n_cmp++; if ({out_p, out_m} !== 4'b0000) begin n_bad++; $display("FAIL stop_outs: got %b want 0000", {out_p, out_m}); end
        n_cmp++; if (state_o !== 9'o101) begin n_bad++; $display("FAIL stop_keeps_state: got %o want 101", state_o); end
        cfg_write(2'd1, 2, 1, 0, 4'b0101);
        do_start();
        present_event(0, rdy, err);
        n_cmp++; if (dual_err !== 1'b1) begin n_bad++; $display("FAIL dual_err_set: got %b want 1", dual_err); end
        n_cmp++; if ({out_p, out_m} !== 4'b0101) begin n_bad++; $display("FAIL dual_outs: got %b want 0101", {out_p, out_m}); end
        present_event(1, rdy, err);
        n_cmp++; if (dual_err !== 1'b0) begin n_bad++; $display("FAIL dual_err_clear: got %b want 0", dual_err); end
        n_cmp++; if (state_o !== 9'o000) begin n_bad++; $display("FAIL dual_diag_state: got %o want 000", state_o); end
    endtask

    task automatic test_reset_mid_run();
        logic rdy, err;
        present_event(0, rdy, err);
        n_cmp++; if (state_o !== 9'o101) begin n_bad++; $display("FAIL premid_state: got %o want 101", state_o); end
        do_reset();
        n_cmp++; if (state_o !== 9'o000) begin n_bad++; $display("FAIL mid_reset_state: got %o want 000", state_o); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL mid_reset_running: got %b want 0", running); end
        n_cmp++; if ({out_p, out_m, dual_err} !== 5'b00000) begin n_bad++; $display("FAIL mid_reset_outs: got %b want 00000", {out_p, out_m, dual_err}); end
        @(negedge clk); ev_valid = 1'b1; ev_id = 3'd0; #1;
        n_cmp++; if (ev_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ev_ready: got %b want 0", ev_ready); end
        @(posedge clk); #1; ev_valid = 1'b0;
        do_start();
        present_event(0, rdy, err);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL cleared_ready: got %b want 1", rdy); end
        n_cmp++; if (state_o !== 9'o000) begin n_bad++; $display("FAIL cleared_state: got %o want 000", state_o); end
        n_cmp++; if ({out_p, out_m} !== 4'b0000) begin n_bad++; $display("FAIL cleared_outs: got %b want 0000", {out_p, out_m}); end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_stop_priority();
        test_cfg_err();
        test_dual_rail();
        test_dual_err();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
